// File: rtl/rr_index_arb_pkg.sv
// Shared constants and state type for the round-robin index arbiter.
// Consumers: rr_pick and rr_index_arb.
package rr_index_arb_pkg;

  localparam int IDX_W_DEF = 5;
  localparam int NONE_IDX  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : rr_index_arb_pkg

// File: rtl/rr_index_arb_pick.sv
// rr_pick: combinational round-robin search over indices 1..N-1.
// Scans from start+1 upward, wraps past N-1 (index 0 is skipped) and ends at start itself.
module rr_pick
  import rr_index_arb_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [(1<<IDX_W)-1:0] eligible,
  input  logic [IDX_W-1:0]      start,
  output logic [IDX_W-1:0]      winner,
  output logic                  any_hit
);

  localparam int N = 1 << IDX_W;

  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;

  // Index 0 is the "no grant" code and can never win.
  assign w_elig = eligible & ~{{(N-1){1'b0}}, 1'b1};

  // w_rot[gi] is the eligibility of the index gi+1 steps after start.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [IDX_W-1:0] w_pos;
      assign w_pos     = start + IDX_W'(gi + 1);
      assign w_rot[gi] = w_elig[w_pos];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
  end

  assign any_hit = |w_rot;
  assign winner  = any_hit ? (start + w_off + IDX_W'(1)) : IDX_W'(NONE_IDX);

endmodule : rr_pick

// File: rtl/rr_index_arb.sv
// rr_index_arb: registered round-robin arbiter emitting the granted index with a valid/ready handshake.
// Optional macro RR_LOCK_EN adds a lock input that re-grants the current index at handshake.
module rr_index_arb
  import rr_index_arb_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<IDX_W)-1:0] req,
  input  logic                  out_ready,
`ifdef RR_LOCK_EN
  input  logic                  lock,
`endif
  output logic [IDX_W-1:0]      idx,
  output logic                  idx_valid
);

  localparam int N = 1 << IDX_W;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic [IDX_W-1:0] r_last;

  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic             w_hold;

  // While granting, a handshake makes the current index the new "last",
  // so the search can start from it directly and avoid a bubble.
  assign w_start = (r_state == GRANT) ? r_idx : r_last;

  rr_pick #(
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible (req),
    .start    (w_start),
    .winner   (w_win),
    .any_hit  (w_any)
  );

`ifdef RR_LOCK_EN
  assign w_hold = lock & req[r_idx];
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= IDX_W'(NONE_IDX);
      r_valid <= 1'b0;
      r_last  <= IDX_W'(N - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_idx   <= w_win;
            r_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (out_ready && !w_hold) begin
            r_last <= r_idx;
            if (w_any) begin
              r_idx <= w_win;
            end else begin
              r_state <= IDLE;
              r_idx   <= IDX_W'(NONE_IDX);
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= IDX_W'(NONE_IDX);
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign idx       = r_idx;
  assign idx_valid = r_valid;

endmodule : rr_index_arb

// File: tb/tb_rr_index_arb.sv
// Self-checking bench for rr_index_arb: directed scenarios plus random traffic vs. a ring-distance model.
// Build with RR_LOCK_EN defined to also exercise the lock port.
module tb_rr_index_arb;

  localparam int IDX_W = 5;
  localparam int N     = 1 << IDX_W;
`ifdef RR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             out_ready;
  logic             lock;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;

  int n_vec;
  int n_err;

  // Model state
  int m_idx;
  int m_valid;
  int m_last;

  rr_index_arb #(
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
`ifdef RR_LOCK_EN
    .lock      (lock),
`endif
    .idx       (idx),
    .idx_valid (idx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Indices 1..N-1 form a ring of N-1 slots; the winner is the set bit at
  // the smallest forward distance after s, with s itself at the far end.
  function automatic int ring_pick(input logic [N-1:0] r, input int s);
    int best;
    int best_d;
    int d;
    best   = 0;
    best_d = N;
    for (int k = 1; k < N; k++) begin
      if (r[k]) begin
        d = (k - s - 1 + 2 * (N - 1)) % (N - 1);
        if (d < best_d) begin
          best_d = d;
          best   = k;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_idx   = 0;
    m_valid = 0;
    m_last  = N - 1;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rdy, input logic lk);
    int w;
    if (m_valid == 0) begin
      w = ring_pick(r, m_last);
      if (w != 0) begin
        m_valid = 1;
        m_idx   = w;
      end
    end else if (rdy) begin
      if (!(LOCK_EN && lk && r[m_idx])) begin
        m_last = m_idx;
        w      = ring_pick(r, m_idx);
        if (w != 0) begin
          m_idx = w;
        end else begin
          m_valid = 0;
          m_idx   = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, check just after the edge.
  task automatic cyc(input logic [N-1:0] r, input logic rdy, input logic lk);
    req       = r;
    out_ready = rdy;
    lock      = lk;
    model_step(r, rdy, lk);
    @(posedge clk);
    #1;
    $display("cyc req=%08h rdy=%0d lock=%0d -> idx=%0d vld=%0d (exp %0d/%0d)",
             r, rdy, lk, idx, idx_valid, m_idx, m_valid);
    chk("idx", int'(idx), m_idx);
    chk("idx_valid", int'(idx_valid), m_valid);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    lock      = 1'b0;
    model_reset();
    #1;
    chk("rst_idx", int'(idx), 0);
    chk("rst_vld", int'(idx_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    out_ready = 1'b0;
    lock  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Two requesters alternate with no bubble.
    cyc(32'h0000_0006, 1'b1, 1'b0);
    chk("alt0", int'(idx), 1);
    cyc(32'h0000_0006, 1'b1, 1'b0);
    chk("alt1", int'(idx), 2);
    cyc(32'h0000_0006, 1'b1, 1'b0);
    chk("alt2", int'(idx), 1);

    // Bit 0 ignored; sole requester 31 re-granted every handshake.
    do_reset();
    cyc(32'h8000_0001, 1'b1, 1'b0);
    chk("solo31a", int'(idx), 31);
    cyc(32'h8000_0001, 1'b1, 1'b0);
    chk("solo31b", int'(idx), 31);
    cyc(32'h0000_0001, 1'b1, 1'b0);
    chk("bit0_only_vld", int'(idx_valid), 0);
    cyc(32'h0000_0001, 1'b1, 1'b0);
    chk("bit0_only_idx", int'(idx), 0);

    // Grant held while stalled; then wrap 31 -> 1 to reach 3.
    do_reset();
    cyc(32'h0000_0020, 1'b0, 1'b0);
    chk("hold_start", int'(idx), 5);
    for (int i = 0; i < 4; i++) cyc(32'h0000_0008, 1'b0, 1'b0);
    chk("hold_end", int'(idx), 5);
    cyc(32'h0000_0008, 1'b1, 1'b0);
    chk("after_hold", int'(idx), 3);

    // Handshake with no requests returns to idle; later request at 8.
    do_reset();
    cyc(32'h0000_0080, 1'b0, 1'b0);
    chk("g7", int'(idx), 7);
    cyc(32'h0000_0000, 1'b1, 1'b0);
    chk("idle_vld", int'(idx_valid), 0);
    cyc(32'h0000_0000, 1'b0, 1'b0);
    cyc(32'h0000_0100, 1'b0, 1'b0);
    chk("g8", int'(idx), 8);

    // Asynchronous reset while idx=12 is pending.
    do_reset();
    cyc(32'h0000_1000, 1'b0, 1'b0);
    chk("g12", int'(idx), 12);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_idx", int'(idx), 0);
    chk("async_vld", int'(idx_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(32'hFFFF_FFFE, 1'b1, 1'b0);
    chk("restart1", int'(idx), 1);

`ifdef RR_LOCK_EN
    do_reset();
    cyc(32'h0000_0030, 1'b0, 1'b0);
    chk("lk_start", int'(idx), 4);
    for (int i = 0; i < 3; i++) begin
      cyc(32'h0000_0030, 1'b1, 1'b1);
      chk("lk_hold", int'(idx), 4);
    end
    cyc(32'h0000_0030, 1'b1, 1'b0);
    chk("lk_release", int'(idx), 5);
    cyc(32'h0000_0020, 1'b1, 1'b1);
    cyc(32'h0000_0000, 1'b1, 1'b1);
`endif

    // Random traffic with sparse and dense request patterns.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'($urandom) & N'($urandom) & N'($urandom);
        2: r = N'(1) << $urandom_range(0, N - 1);
        default: r = N'($urandom);
      endcase
      cyc(r, 1'($urandom_range(0, 1)), LOCK_EN ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rr_index_arb
